// File: rtl/data_ram_ctrl.sv
// data_ram_ctrl: valid/ready data-memory controller with wait states,
// funct3 sub-word load/store handling and error responses.
module data_ram_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS_INIT =
        4'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q;
    logic [2:0]          op_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic [31:0]         mem_q [DEPTH_WORDS];

    logic                transfer;
    logic                capture;
    logic                commit;
    logic                use_in;
    logic                a_we;
    logic [2:0]          a_op;
    logic [ADDR_W-1:0]   a_addr;
    logic [31:0]         a_wdata;
    logic [1:0]          lane;
    logic [IDX_W-1:0]    idx;
    logic                a_err;
    logic [3:0]          be;
    logic [31:0]         wd;
    logic [31:0]         word;
    logic [31:0]         bsh;
    logic [31:0]         hsh;
    logic [31:0]         wmerge;
    logic [31:0]         rdata_d;

    assign req_ready = (state_q != S_WAIT);
    assign transfer  = req_valid & req_ready;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign busy      = (state_q != S_IDLE);

    // Next state: IDLE/RESP accept, WAIT counts down to the response.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        commit  = 1'b0;
        use_in  = 1'b0;
        unique case (state_q)
            S_IDLE, S_RESP: begin
                state_d = S_IDLE;
                if (transfer) begin
                    capture = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                        use_in  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WS_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decode the access being committed: lanes, error and load data.
    always_comb begin
        a_we    = use_in ? req_we    : we_q;
        a_op    = use_in ? req_op    : op_q;
        a_addr  = use_in ? req_addr  : addr_q;
        a_wdata = use_in ? req_wdata : wdata_q;
        lane    = a_addr[1:0];
        idx     = a_addr[IDX_W+1:2];
        a_err   = ((a_addr >> (IDX_W + 2)) != '0);
        unique case (a_op)
            3'b000:         a_err = a_err;
            3'b001:         a_err = a_err | a_addr[0];
            3'b010:         a_err = a_err | (a_addr[1:0] != 2'b00);
            3'b100:         a_err = a_err | a_we;
            3'b101:         a_err = a_err | a_we | a_addr[0];
            default:        a_err = 1'b1;
        endcase
        unique case (a_op[1:0])
            2'b00: begin
                be = 4'b0001 << lane;
                wd = {4{a_wdata[7:0]}};
            end
            2'b01: begin
                be = 4'b0011 << {lane[1], 1'b0};
                wd = {2{a_wdata[15:0]}};
            end
            default: begin
                be = 4'b1111;
                wd = a_wdata;
            end
        endcase
        word = mem_q[idx];
        bsh  = word >> {lane, 3'b000};
        hsh  = word >> {lane[1], 4'b0000};
        for (int i = 0; i < 4; i++) begin
            wmerge[8*i +: 8] = be[i] ? wd[8*i +: 8] : word[8*i +: 8];
        end
        unique case (a_op)
            3'b000:  rdata_d = {{24{bsh[7]}}, bsh[7:0]};
            3'b100:  rdata_d = {24'd0, bsh[7:0]};
            3'b001:  rdata_d = {{16{hsh[15]}}, hsh[15:0]};
            3'b101:  rdata_d = {16'd0, hsh[15:0]};
            default: rdata_d = word;
        endcase
        if (a_err || a_we) begin
            rdata_d = 32'd0;
        end
    end

    // Control state, captured request and registered response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            op_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                we_q    <= req_we;
                op_q    <= req_op;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (commit) begin
                err_q   <= a_err;
                rdata_q <= rdata_d;
            end
        end
    end

    // Data array: lane-merged word write on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (commit && a_we && !a_err) begin
            mem_q[idx] <= wmerge;
        end
    end

endmodule

// File: tb/tb_data_ram_ctrl.sv
// tb_data_ram_ctrl: randomized bench for data_ram_ctrl against a
// byte-addressed reference memory, with 0 and 3 wait states.
module tb_data_ram_ctrl;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic        v0, v1;
    logic        we;
    logic [2:0]  op;
    logic [31:0] addr, wdata;
    logic        ready0, rv0, err0, busy0;
    logic        ready1, rv1, err1, busy1;
    logic [31:0] rd0, rd1;

    int passed = 0;
    int total  = 0;

    logic [7:0] mm [2][DEPTH*4];

    always #5 clk = ~clk;

    data_ram_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(ready0),
        .req_we(we), .req_op(op), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0), .busy(busy0)
    );

    data_ram_ctrl #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u1 (
        .clk(clk), .rst(rst1), .req_valid(v1), .req_ready(ready1),
        .req_we(we), .req_op(op), .req_addr(addr), .req_wdata(wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1), .busy(busy1)
    );

    // Reference: byte memory, access rules applied directly.
    function automatic void model(input int d, input logic w,
                                  input logic [2:0] o, input logic [31:0] a,
                                  input logic [31:0] wdv,
                                  output logic e, output logic [31:0] r);
        int n;
        logic [31:0] v;
        e = (o == 3'd3) || (o == 3'd6) || (o == 3'd7) ||
            (o >= 3'd4 && w) ||
            ((o == 3'd1 || o == 3'd5) && a[0]) ||
            (o == 3'd2 && a[1:0] != 2'b00) ||
            (a / 4 >= DEPTH);
        r = 32'd0;
        if (e) return;
        n = (o[1:0] == 2'b00) ? 1 : (o[1:0] == 2'b01) ? 2 : 4;
        if (w) begin
            for (int i = 0; i < n; i++) mm[d][a + i] = wdv[8*i +: 8];
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mm[d][a + i];
        case (o)
            3'd0:    r = {{24{v[7]}}, v[7:0]};
            3'd1:    r = {{16{v[15]}}, v[15:0]};
            3'd4:    r = {24'd0, v[7:0]};
            3'd5:    r = {16'd0, v[15:0]};
            default: r = v;
        endcase
    endfunction

    // One access on u0 from a negedge; leaves v0 high for back-to-back.
    task automatic xfer0(input logic w, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] wdv,
                         output logic gr, output logic gv,
                         output logic ge, output logic [31:0] gd);
        we = w; op = o; addr = a; wdata = wdv; v0 = 1'b1;
        #1 gr = ready0;
        @(negedge clk);
        gv = rv0; ge = err0; gd = rd0;
    endtask

    // One access on u1; counts wait cycles that look wrong.
    task automatic xfer1(input logic w, input logic [2:0] o,
                         input logic [31:0] a, input logic [31:0] wdv,
                         output int bad, output logic gv,
                         output logic ge, output logic [31:0] gd);
        we = w; op = o; addr = a; wdata = wdv; v1 = 1'b1;
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            v1 = 1'b0;
            if (ready1 !== 1'b0 || busy1 !== 1'b1 || rv1 !== 1'b0) bad++;
        end
        @(negedge clk);
        gv = rv1; ge = err1; gd = rd1;
    endtask

    task automatic test_reset();
        total++;
        if ({rv0, err0, busy0, ready0, rd0} !== {4'b0001, 32'd0}) begin
            $display("FAIL reset0: got v/e/b/r=%b%b%b%b rd=%h want 0001 0",
                     rv0, err0, busy0, ready0, rd0);
        end else passed++;
        total++;
        if ({rv1, err1, busy1, ready1, rd1} !== {4'b0001, 32'd0}) begin
            $display("FAIL reset1: got v/e/b/r=%b%b%b%b rd=%h want 0001 0",
                     rv1, err1, busy1, ready1, rd1);
        end else passed++;
    endtask

    task automatic test_init();
        logic gr, gv, ge, me;
        logic [31:0] gd, mr, x;
        int bad, nerr;
        nerr = 0;
        for (int i = 0; i < DEPTH; i++) begin
            x = $urandom;
            model(0, 1'b1, 3'd2, i * 4, x, me, mr);
            xfer0(1'b1, 3'd2, i * 4, x, gr, gv, ge, gd);
            if (gv !== 1'b1 || ge !== 1'b0) nerr++;
        end
        v0 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            x = $urandom;
            model(1, 1'b1, 3'd2, i * 4, x, me, mr);
            xfer1(1'b1, 3'd2, i * 4, x, bad, gv, ge, gd);
            if (gv !== 1'b1 || ge !== 1'b0 || bad != 0) nerr++;
        end
        total++;
        if (nerr != 0) $display("FAIL init: %0d bad writes, want 0", nerr);
        else passed++;
    endtask

    task automatic test_store_load();
        logic gr, gv, ge, me;
        logic [31:0] gd, mr;
        model(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, me, mr);
        xfer0(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, gr, gv, ge, gd);
        total++;
        if ({gr, gv, ge, gd} !== {3'b110, 32'd0}) begin
            $display("FAIL sw: rdy/v/e=%b%b%b rd=%h want 110 0", gr, gv, ge, gd);
        end else passed++;
        xfer0(1'b0, 3'd2, 32'h10, 32'h0, gr, gv, ge, gd);
        total++;
        if ({gr, gv, ge, gd} !== {3'b110, 32'hDEADBEEF}) begin
            $display("FAIL lw: rdy/v/e=%b%b%b rd=%h want 110 deadbeef",
                     gr, gv, ge, gd);
        end else passed++;
        v0 = 1'b0;
        @(negedge clk);
        total++;
        if ({rv0, busy0, rd0} !== {2'b00, 32'hDEADBEEF}) begin
            $display("FAIL idle_hold: v/b=%b%b rd=%h want 00 deadbeef",
                     rv0, busy0, rd0);
        end else passed++;
    endtask

    task automatic test_subword();
        logic [2:0]  ops [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] ads [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
        logic [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE,
                                 32'hFFFFBEEF, 32'h0000DEAD};
        logic gr, gv, ge;
        logic [31:0] gd;
        for (int i = 0; i < 4; i++) begin
            xfer0(1'b0, ops[i], ads[i], 32'h0, gr, gv, ge, gd);
            total++;
            if ({gv, ge, gd} !== {2'b10, exp[i]}) begin
                $display("FAIL subword%0d: v/e=%b%b rd=%h want 10 %h",
                         i, gv, ge, gd, exp[i]);
            end else passed++;
        end
        v0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sb();
        logic gr, gv, ge, me;
        logic [31:0] gd, mr;
        model(0, 1'b1, 3'd0, 32'h11, 32'h55, me, mr);
        xfer0(1'b1, 3'd0, 32'h11, 32'h55, gr, gv, ge, gd);
        xfer0(1'b0, 3'd2, 32'h10, 32'h0, gr, gv, ge, gd);
        total++;
        if ({gv, ge, gd} !== {2'b10, 32'hDEAD55EF}) begin
            $display("FAIL sb: v/e=%b%b rd=%h want 10 dead55ef", gv, ge, gd);
        end else passed++;
        v0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_errors();
        logic        ws [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [2:0]  os [6] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4, 3'd2};
        logic [31:0] as [6] = '{32'h12, 32'h01, 32'h10,
                                32'(DEPTH * 4), 32'h10, 32'h8000_0010};
        logic gr, gv, ge, me;
        logic [31:0] gd, mr;
        for (int i = 0; i < 6; i++) begin
            xfer0(ws[i], os[i], as[i], 32'h1234_5678, gr, gv, ge, gd);
            total++;
            if ({gv, ge, gd} !== {2'b11, 32'd0}) begin
                $display("FAIL err%0d: v/e=%b%b rd=%h want 11 0",
                         i, gv, ge, gd);
            end else passed++;
        end
        model(0, 1'b0, 3'd2, 32'h10, 32'h0, me, mr);
        xfer0(1'b0, 3'd2, 32'h10, 32'h0, gr, gv, ge, gd);
        total++;
        if ({gv, ge, gd} !== {2'b10, mr}) begin
            $display("FAIL err_readback: rd=%h want %h", gd, mr);
        end else passed++;
        model(0, 1'b0, 3'd2, 32'(DEPTH * 4 - 4), 32'h0, me, mr);
        xfer0(1'b0, 3'd2, 32'(DEPTH * 4 - 4), 32'h0, gr, gv, ge, gd);
        total++;
        if ({gv, ge, gd} !== {2'b10, mr}) begin
            $display("FAIL last_word: v/e=%b%b rd=%h want 10 %h",
                     gv, ge, gd, mr);
        end else passed++;
        v0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random0();
        logic gr, gv, ge, me, w;
        logic [2:0] o;
        logic [31:0] gd, mr, a, x;
        for (int n = 0; n < 300; n++) begin
            w = 1'($urandom_range(0, 1));
            o = 3'($urandom_range(0, 7));
            a = $urandom_range(0, DEPTH * 4 + 15);
            if ($urandom_range(0, 15) == 0) a = $urandom;
            x = $urandom;
            model(0, w, o, a, x, me, mr);
            xfer0(w, o, a, x, gr, gv, ge, gd);
            total++;
            if ({gr, gv, ge, gd} !== {2'b11, me, mr}) begin
                $display("FAIL rand0 #%0d op=%0d we=%b a=%h: rdy/v/e=%b%b%b rd=%h want 11%b %h",
                         n, o, w, a, gr, gv, ge, gd, me, mr);
            end else passed++;
        end
        v0 = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_states();
        logic me;
        logic [31:0] mr;
        model(1, 1'b0, 3'd2, 32'h40, 32'h0, me, mr);
        we = 1'b0; op = 3'd2; addr = 32'h40; v1 = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            v1 = 1'b0;
            total++;
            if ({ready1, busy1, rv1} !== 3'b010) begin
                $display("FAIL wait t+%0d: rdy/busy/v=%b%b%b want 010",
                         k, ready1, busy1, rv1);
            end else passed++;
        end
        @(negedge clk);
        total++;
        if ({rv1, ready1, err1, rd1} !== {3'b110, mr}) begin
            $display("FAIL wait_rsp: v/rdy/e=%b%b%b rd=%h want 110 %h",
                     rv1, ready1, err1, rd1, mr);
        end else passed++;
        @(negedge clk);
        total++;
        if ({rv1, busy1} !== 2'b00) begin
            $display("FAIL wait_pulse: v/busy=%b%b want 00", rv1, busy1);
        end else passed++;
    endtask

    task automatic test_random1();
        logic gv, ge, me, w;
        logic [2:0] o;
        logic [31:0] gd, mr, a, x;
        int bad;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            o = 3'($urandom_range(0, 7));
            a = $urandom_range(0, DEPTH * 4 + 15);
            x = $urandom;
            model(1, w, o, a, x, me, mr);
            xfer1(w, o, a, x, bad, gv, ge, gd);
            total++;
            if (bad != 0 || {gv, ge, gd} !== {1'b1, me, mr}) begin
                $display("FAIL rand1 #%0d op=%0d we=%b a=%h: badwait=%0d v/e=%b%b rd=%h want 0 1%b %h",
                         n, o, w, a, bad, gv, ge, gd, me, mr);
            end else passed++;
        end
    endtask

    task automatic test_reset_mid();
        logic gv, ge, me;
        logic [31:0] gd, mr;
        int bad, pulses;
        model(1, 1'b1, 3'd2, 32'h20, 32'hA5A5_0001, me, mr);
        xfer1(1'b1, 3'd2, 32'h20, 32'hA5A5_0001, bad, gv, ge, gd);
        xfer1(1'b0, 3'd2, 32'h20, 32'h0, bad, gv, ge, gd);
        we = 1'b1; op = 3'd2; addr = 32'h20; wdata = 32'h0BAD_F00D;
        v1 = 1'b1;
        @(negedge clk);
        v1 = 1'b0;
        rst1 = 1'b0;
        #1;
        total++;
        if ({rv1, busy1, ready1, err1, rd1} !== {4'b0010, 32'd0}) begin
            $display("FAIL rst_mid: v/b/r/e=%b%b%b%b rd=%h want 0010 0",
                     rv1, busy1, ready1, err1, rd1);
        end else passed++;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst1 = 1'b1;
            if (rv1 !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) $display("FAIL rst_no_rsp: %0d pulses want 0", pulses);
        else passed++;
        model(1, 1'b0, 3'd2, 32'h20, 32'h0, me, mr);
        xfer1(1'b0, 3'd2, 32'h20, 32'h0, bad, gv, ge, gd);
        total++;
        if ({gv, ge, gd} !== {2'b10, mr}) begin
            $display("FAIL rst_keep: rd=%h want %h", gd, mr);
        end else passed++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst0 = 1'b0; rst1 = 1'b0; v0 = 1'b0; v1 = 1'b0;
        we = 1'b0; op = 3'd0; addr = 32'd0; wdata = 32'd0;
        #3;
        test_reset();
        repeat (2) @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1;
        @(negedge clk);
        test_init();
        test_store_load();
        test_subword();
        test_sb();
        test_errors();
        test_random0();
        test_wait_states();
        test_random1();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
